// File: rtl/s13207_sel_pipe.sv
// s13207_sel_pipe: two-stage valid/ready channel-select pipeline with group/enable match.
// Optional saturating hit counter: define S13207_SEL_PIPE_HITCNT_EN. The force input is force_ones (force is reserved).
module s13207_sel_pipe #(
   parameter int            CH     = 16,
   parameter int            W      = 1,
   parameter int            GW     = 4,
   parameter logic [GW-1:0] GMATCH = GW'(4'b1111),
   localparam int           SW     = $clog2(CH)
) (
   input  logic            CK,
   input  logic            RST,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      en,
   input  logic [GW-1:0]   grp,
   input  logic [SW-1:0]   sel,
   input  logic            force_ones,
   input  logic [CH*W-1:0] data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [W-1:0]    out_data,
   output logic            out_hit,
   output logic [15:0]     hit_cnt
);

   // Bit k set when index k names a real channel; all ones when CH is a power of two.
   localparam int            NSEL  = 1 << SW;
   localparam logic [NSEL-1:0] CH_OK = {NSEL{1'b1}} >> (NSEL - CH);

   logic          s1_valid_q, s1_valid_d;
   logic          s1_hit_q, s1_hit_d;
   logic          s1_force_q, s1_force_d;
   logic [SW-1:0] s1_sel_q, s1_sel_d;
   logic [W-1:0]  s1_word_q, s1_word_d;
   logic [W-1:0]  sel_word;

   logic          out_valid_q, out_valid_d;
   logic          out_hit_q, out_hit_d;
   logic [W-1:0]  out_data_q, out_data_d;

   logic          s1_adv, in_fire, out_fire;

   always_comb begin : handshake
      out_fire = out_valid_q && out_ready;
      s1_adv   = s1_valid_q && (!out_valid_q || out_ready);
      in_ready = !s1_valid_q || s1_adv;
      in_fire  = in_valid && in_ready;
   end

   always_comb begin : stage1_next
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      sel_word = '0;
      for (int k = 0; k < CH; k++) begin
         if (sel == SW'(k)) sel_word = data[k*W +: W];
      end
      s1_valid_d = s1_valid_q;
      s1_hit_d   = s1_hit_q;
      s1_force_d = s1_force_q;
      s1_sel_d   = s1_sel_q;
      s1_word_d  = s1_word_q;
      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_hit_d   = (en == 5'b00100) && (grp == GMATCH);
         s1_force_d = force_ones;
         s1_sel_d   = sel;
         s1_word_d  = sel_word;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end
   end

   always_comb begin : stage2_next
      out_valid_d = out_valid_q;
      out_hit_d   = out_hit_q;
      out_data_d  = out_data_q;
      if (s1_adv) begin
         out_valid_d = 1'b1;
         out_hit_d   = s1_hit_q && !s1_force_q;
         out_data_d  = s1_force_q ? '1 :
                       ((s1_hit_q && CH_OK[s1_sel_q]) ? s1_word_q : '0);
      end else if (out_fire) begin
         out_valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CK) begin
      if (RST) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_hit_q   <= 1'b0;
         out_data_q  <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         out_hit_q   <= out_hit_d;
         out_data_q  <= out_data_d;
      end
   end

   // NOTE: stage-1 payload is qualified by s1_valid_q, so it carries no reset.
   always_ff @(posedge CK) begin
      s1_hit_q   <= s1_hit_d;
      s1_force_q <= s1_force_d;
      s1_sel_q   <= s1_sel_d;
      s1_word_q  <= s1_word_d;
   end

`ifdef S13207_SEL_PIPE_HITCNT_EN
   logic [15:0] hit_cnt_q, hit_cnt_d;

   always_comb begin : hit_cnt_next
      hit_cnt_d = hit_cnt_q;
      if (out_fire && out_hit_q && (hit_cnt_q != 16'hFFFF)) hit_cnt_d = hit_cnt_q + 16'd1;
   end

   always_ff @(posedge CK) begin
      if (RST) hit_cnt_q <= '0;
      else     hit_cnt_q <= hit_cnt_d;
   end

   assign hit_cnt = hit_cnt_q;
`else
   assign hit_cnt = '0;
`endif

   assign out_valid = out_valid_q;
   assign out_hit   = out_hit_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_s13207_sel_pipe.sv
// Scoreboard bench for s13207_sel_pipe: default instance (CH=16, W=1) plus a CH=64, W=8 instance.
module tb_s13207_sel_pipe;

   localparam int CH = 16;
   localparam int W  = 1;

   logic            CK = 1'b0;
   logic            RST;
   logic            in_valid, in_ready, force_ones, out_valid, out_ready, out_hit;
   logic [4:0]      en;
   logic [3:0]      grp;
   logic [3:0]      sel;
   logic [CH*W-1:0] data;
   logic [W-1:0]    out_data;
   logic [15:0]     hit_cnt;

   logic            b_in_valid, b_in_ready, b_force, b_out_valid, b_out_hit;
   logic [4:0]      b_en;
   logic [3:0]      b_grp;
   logic [5:0]      b_sel;
   logic [511:0]    b_data;
   logic [7:0]      b_out_data;
   logic [15:0]     b_hit_cnt;

   always #5 CK = ~CK;

   s13207_sel_pipe u_dut (
      .CK(CK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .en(en), .grp(grp),
      .sel(sel), .force_ones(force_ones), .data(data), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_hit(out_hit), .hit_cnt(hit_cnt)
   );

   s13207_sel_pipe #(.CH(64), .W(8)) u_dut64 (
      .CK(CK), .RST(RST), .in_valid(b_in_valid), .in_ready(b_in_ready), .en(b_en), .grp(b_grp),
      .sel(b_sel), .force_ones(b_force), .data(b_data), .out_valid(b_out_valid),
      .out_ready(1'b1), .out_data(b_out_data), .out_hit(b_out_hit), .hit_cnt(b_hit_cnt)
   );

   int n_cmp = 0;
   int n_err = 0;
   int n_out = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   typedef struct packed {
      logic [W-1:0] d;
      logic         h;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        sb_e;
   logic        m_hit;
   logic [15:0] exp_cnt = '0;

   // Scoreboard: transfers are decided by signals stable at the falling edge.
   always @(negedge CK) begin
      if (RST) begin
         sb_q.delete();
         exp_cnt = '0;
      end else begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected_out", 32'(out_valid), 32'd0);
            end else begin
               sb_e = sb_q.pop_front();
               check("sb_data", 32'(out_data), 32'(sb_e.d));
               check("sb_hit", 32'(out_hit), 32'(sb_e.h));
               n_out++;
`ifdef S13207_SEL_PIPE_HITCNT_EN
               if (sb_e.h && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
            end
         end
         if (in_valid && in_ready) begin
            m_hit  = (en == 5'b00100) && (grp == 4'b1111);
            sb_e.h = m_hit && !force_ones;
            sb_e.d = force_ones ? '1 : (m_hit ? data[sel*W +: W] : '0);
            sb_q.push_back(sb_e);
         end
      end
   end

   task automatic beat(input logic [4:0] e, input logic [3:0] g, input logic [3:0] s,
                       input logic f, input logic [CH*W-1:0] d);
      logic ok;
      in_valid = 1'b1; en = e; grp = g; sel = s; force_ones = f; data = d;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge CK);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge CK); #1;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CK);
         if (sb_q.size() == 0) break;
      end
      @(posedge CK); #1;
      check("drain_empty", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      logic [7:0] b_want;
      RST = 1'b1; in_valid = 1'b0; en = '0; grp = '0; sel = '0; force_ones = 1'b0;
      data = '0; out_ready = 1'b1;
      b_in_valid = 1'b0; b_en = 5'b00100; b_grp = 4'b1111; b_sel = '0; b_force = 1'b0; b_data = '0;
      repeat (3) @(posedge CK);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_hit", 32'(out_hit), 32'd0);
      check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
      RST = 1'b0;
      @(negedge CK);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge CK); #1;

      // Single hit: ch5 = 1, latency two cycles.
      in_valid = 1'b1; en = 5'b00100; grp = 4'b1111; sel = 4'd5; force_ones = 1'b0;
      data = 16'h0020;
      @(negedge CK);
      check("lat_accept", 32'(in_ready), 32'd1);
      @(posedge CK); #1;
      in_valid = 1'b0;
      check("lat_cycle1_idle", 32'(out_valid), 32'd0);
      @(posedge CK); #1;
      check("lat_cycle2_valid", 32'(out_valid), 32'd1);
      drain();
      check("hit_cnt_first", 32'(hit_cnt), 32'(exp_cnt));

      // Group mismatch, wrong enable, force, and channel boundaries.
      beat(5'b00100, 4'b1110, 4'd1, 1'b0, 16'hFFFF);
      beat(5'b00100, 4'b1110, 4'd1, 1'b1, 16'hFFFF);
      beat(5'b00101, 4'b1111, 4'd2, 1'b0, 16'hFFFF);
      beat(5'b00100, 4'b1111, 4'd0, 1'b0, 16'h0001);
      beat(5'b00100, 4'b1111, 4'd15, 1'b0, 16'h7FFF);
      beat(5'b00100, 4'b1111, 4'd15, 1'b0, 16'h8000);
      drain();
      check("hit_cnt_mixed", 32'(hit_cnt), 32'(exp_cnt));

      // Eight-beat stream with out_ready low for cycles 3-6.
      n0 = n_out;
      fork
         begin
            for (int i = 0; i < 8; i++)
               beat(5'b00100, (i == 3) ? 4'b0000 : 4'b1111, 4'(i * 2), 1'b0, 16'($urandom));
            in_valid = 1'b0;
         end
         begin
            repeat (2) @(posedge CK);
            #1 out_ready = 1'b0;
            repeat (2) @(posedge CK);
            @(negedge CK);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            repeat (2) @(posedge CK);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      check("stream_count", 32'(n_out - n0), 32'd8);
      check("hit_cnt_stream", 32'(hit_cnt), 32'(exp_cnt));

      // Reset with both stages full discards both beats.
      out_ready = 1'b0;
      beat(5'b00100, 4'b1111, 4'd3, 1'b0, 16'h0008);
      beat(5'b00100, 4'b1111, 4'd4, 1'b1, 16'h0010);
      in_valid = 1'b0;
      @(negedge CK);
      check("full_in_ready", 32'(in_ready), 32'd0);
      @(posedge CK); #1;
      RST = 1'b1;
      @(posedge CK); #1;
      RST = 1'b0;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_out_data", 32'(out_data), 32'd0);
      check("mid_rst_hit_cnt", 32'(hit_cnt), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      n0 = n_out;
      repeat (6) @(posedge CK);
      #1;
      check("mid_rst_no_output", 32'(n_out - n0), 32'd0);

      // Hit counter saturation (or constant zero without the counter).
`ifdef S13207_SEL_PIPE_HITCNT_EN
      for (int i = 0; i < 65536; i++) beat(5'b00100, 4'b1111, 4'd7, 1'b0, 16'h0080);
      drain();
      check("hit_cnt_saturate", 32'(hit_cnt), 32'h0000FFFF);
`else
      for (int i = 0; i < 6; i++) beat(5'b00100, 4'b1111, 4'd7, 1'b0, 16'h0080);
      drain();
      check("hit_cnt_disabled", 32'(hit_cnt), 32'd0);
`endif

      // CH=64, W=8: channel 63 sampled at acceptance, data changed right after.
      for (int k = 0; k < 16; k++) b_data[k*32 +: 32] = $urandom;
      b_data[63*8 +: 8] = 8'hA5;
      b_want = 8'hA5;
      b_sel = 6'd63;
      b_in_valid = 1'b1;
      @(negedge CK);
      check("ch64_accept", 32'(b_in_ready), 32'd1);
      @(posedge CK); #1;
      b_in_valid = 1'b0;
      b_data = ~b_data;
      for (int i = 0; i < 20; i++) begin
         @(negedge CK);
         if (b_out_valid) break;
      end
      check("ch64_valid", 32'(b_out_valid), 32'd1);
      check("ch64_sel63_data", 32'(b_out_data), 32'(b_want));
      check("ch64_hit", 32'(b_out_hit), 32'd1);

      @(posedge CK); #1;
      b_force = 1'b1;
      b_in_valid = 1'b1;
      @(posedge CK); #1;
      b_in_valid = 1'b0;
      b_force = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CK);
         if (b_out_valid) break;
      end
      check("ch64_force_data", 32'(b_out_data), 32'h000000FF);
      check("ch64_force_hit", 32'(b_out_hit), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
